spi_slv16: RTL and testbench
============================

# spi_slv16

16-bit SPI responder that serves as the far end of SPI_mstr16 on the same serial bus. It oversamples SS_n, SCLK and MOSI on the system clock, captures a 16-bit command frame from the master, and returns a preloaded 16-bit response on MISO during the same frame. It runs in SPI mode 3: SCLK idles high, data changes on the falling edge and is sampled on the rising edge, MSB first. It sits in peripheral/sensor models and device-side logic that answer the team's SPI masters.

## Interface
- Parameters: none (frame width fixed at 16, synchronizer depth fixed at 2).
- clk  in  1  system clock; the only clock, and SCLK is treated as data.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select from the master, asynchronous, active low.
- SCLK  in  1  serial clock from the master, asynchronous, idles high.
- MOSI  in  1  serial data from the master, asynchronous.
- MISO  out  1  serial data to the master.
- tx_data  in  16  response word for the next frame.
- tx_ld  in  1  one-clk strobe that writes tx_data into the response buffer.
- rx_data  out  16  last complete frame received.
- rx_rdy  out  1  sticky flag: a new rx_data is valid.
- clr_rx_rdy  in  1  clears rx_rdy.
- frm_err  out  1  one-clk pulse: a frame ended with a rising-SCLK count other than 16.

## Operation
- **Synchronizers.** SS_n, SCLK and MOSI each pass through 2 meta flops plus 1 history flop. SS_n and SCLK flops reset to 1, MOSI flops reset to 0.
  - sclk_rise = ff2 & ~ff3, sclk_fall = ~ff2 & ff3.
  - ss_fall and ss_rise are detected the same way.
- **State machine:** IDLE, ACTIVE.
  - IDLE → ACTIVE on ss_fall. On that transition: load tx_shft from tx_buf, clear bitcnt, set first_fall, clear rx_rdy.
  - In ACTIVE, on sclk_rise:
    - rx_shft <= {rx_shft[14:0], MOSI_ff2}.
    - bitcnt increments and saturates at 17.
  - In ACTIVE, on sclk_fall:
    - If first_fall is set, clear first_fall and leave tx_shft unchanged.
    - Otherwise tx_shft <= {tx_shft[14:0], 1'b0}.
  - ACTIVE → IDLE on ss_rise.
    - If bitcnt == 16: rx_data <= rx_shft and set rx_rdy.
    - Otherwise: pulse frm_err and leave rx_data and rx_rdy unchanged.
  - SCLK and MOSI edges are ignored in IDLE.
- **MISO** = tx_shft[15] while in ACTIVE, and 0 in IDLE.
- **tx_buf** updates on tx_ld in any state. It never disturbs tx_shft mid-frame; the new value is used from the next ss_fall.
- **rx_rdy**
  - If clr_rx_rdy and a set in the same cycle: set wins.
  - A new frame start (ss_fall) clears rx_rdy.
- **Reset values:** MISO=0, rx_data=0, rx_rdy=0, frm_err=0, tx_buf=0, state=IDLE. rst_n asserted mid-frame aborts the frame with no frm_err.

## Timing
- Required clock ratio: SCLK high and low phases each ≥ 4 clk periods. SPI_mstr16 gives 16 clk per phase.
- Pin-to-detect latency is 2 clk. An edge registered by ff1 at clk edge k takes effect at edge k+2.
- rx_rdy rises at edge k+2 after the SS_n rising edge is first sampled at edge k. frm_err pulses in that same cycle.
- The first MISO bit (tx_buf[15]) is valid 3 clk after SS_n falls. Each subsequent bit is valid 3 clk after the SCLK fall that shifts it, i.e. ≥ 1 clk before the next SCLK rise.
- rx_data is stable from rx_rdy assertion until the next successful frame end.

## Structure
- Shared package spi_pkg holds:
  - the state typedef `spi_slv_state_t` {IDLE, ACTIVE};
  - localparam SPI_FRAME_BITS = 16.
- One sub-module, sync_edge (3-flop synchronizer with rise/fall outputs and a reset-value input), instantiated for SS_n and SCLK. MOSI uses its ff2 output only.

## Test plan
- **Back-to-back frames.** tx_ld with tx_data=16'hA5C3, then SPI_mstr16 sends cmd=16'h1234 → master rd_data=16'hA5C3, rx_data=16'h1234, rx_rdy=1 three clk after SS_n rises. Repeat with 16'hFFFF/16'h0001 → both words correct, with no stale bit from the prior frame.
- **Short frame.** Drive SS_n low, 10 SCLK cycles, SS_n high → frm_err pulses for exactly 1 clk, rx_rdy stays 0, rx_data is unchanged.
- **Long frame.** 17 SCLK cycles → frm_err pulses, rx_data is unchanged.
- **Flag handshake.** Assert clr_rx_rdy in the same cycle rx_rdy sets → rx_rdy=1. One cycle later clr_rx_rdy=1 → rx_rdy=0.
- **tx_ld mid-frame.** tx_ld=16'h0F0F during a frame sending 16'h8001 → MISO finishes with 16'h8001 and the next frame returns 16'h0F0F.
- **Reset mid-frame.** rst_n low after 8 bits → MISO=0, rx_rdy=0, state=IDLE. The next full frame with cmd=16'hBEEF → rx_data=16'hBEEF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI responder.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_CNT_W      = 5;

  // Rising-SCLK count saturates one past a full frame, so long frames stay detectable.
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_FULL = SPI_CNT_W'(SPI_FRAME_BITS);
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_SAT  = SPI_CNT_W'(SPI_FRAME_BITS + 1);

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

endpackage

// File: rtl/spi_slv16_if.sv
// Bus bundle between the SPI responder and its master / host-side logic.
interface spi_slv16_if;
  import spi_pkg::*;

  logic                      SS_n;
  logic                      SCLK;
  logic                      MOSI;
  logic                      MISO;
  logic [SPI_FRAME_BITS-1:0] tx_data;
  logic                      tx_ld;
  logic [SPI_FRAME_BITS-1:0] rx_data;
  logic                      rx_rdy;
  logic                      clr_rx_rdy;
  logic                      frm_err;

  modport slave (
    input  SS_n, SCLK, MOSI, tx_data, tx_ld, clr_rx_rdy,
    output MISO, rx_data, rx_rdy, frm_err
  );

  modport master (
    output SS_n, SCLK, MOSI, tx_data, tx_ld, clr_rx_rdy,
    input  MISO, rx_data, rx_rdy, frm_err
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop, with rise/fall detect on the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_ff1, r_ff2, r_ff3;

  // Shift the asynchronous input through meta and history flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= i_rst_val;
      r_ff2 <= i_rst_val;
      r_ff3 <= i_rst_val;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
    end
  end

  assign o_rise = r_ff2 & ~r_ff3;
  assign o_fall = ~r_ff2 & r_ff3;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit mode-3 SPI responder: captures a command frame, returns a preloaded response.
module spi_slv16
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  spi_slv16_if.slave bus
);

  localparam int W = SPI_FRAME_BITS;

  logic w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall;
  logic r_mosi_ff1, r_mosi_ff2;

  spi_slv_state_t       r_state, w_state_nxt;
  logic [W-1:0]         r_tx_buf, w_tx_buf_nxt;
  logic [W-1:0]         r_tx_shft, w_tx_shft_nxt;
  logic [W-1:0]         r_rx_shft, w_rx_shft_nxt;
  logic [W-1:0]         r_rx_data, w_rx_data_nxt;
  logic [SPI_CNT_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic                 r_first_fall, w_first_fall_nxt;
  logic                 r_rx_rdy, w_rx_rdy_nxt;
  logic                 r_frm_err, w_frm_err_nxt;
  logic                 w_rdy_set, w_rdy_clr;

  sync_edge u_ss_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rst_val(1'b1),
    .i_d      (bus.SS_n),
    .o_rise   (w_ss_rise),
    .o_fall   (w_ss_fall)
  );

  sync_edge u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rst_val(1'b1),
    .i_d      (bus.SCLK),
    .o_rise   (w_sclk_rise),
    .o_fall   (w_sclk_fall)
  );

  // MOSI only needs a level aligned with the SCLK edge detect, so no history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_ff1 <= 1'b0;
      r_mosi_ff2 <= 1'b0;
    end else begin
      r_mosi_ff1 <= bus.MOSI;
      r_mosi_ff2 <= r_mosi_ff1;
    end
  end

  // Next-state and datapath update for the frame state machine.
  always_comb begin
    w_state_nxt      = r_state;
    w_tx_buf_nxt     = r_tx_buf;
    w_tx_shft_nxt    = r_tx_shft;
    w_rx_shft_nxt    = r_rx_shft;
    w_rx_data_nxt    = r_rx_data;
    w_bitcnt_nxt     = r_bitcnt;
    w_first_fall_nxt = r_first_fall;
    w_rx_rdy_nxt     = r_rx_rdy;
    w_frm_err_nxt    = 1'b0;
    w_rdy_set        = 1'b0;
    w_rdy_clr        = 1'b0;

    if (bus.tx_ld) w_tx_buf_nxt = bus.tx_data;

    unique case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt      = ACTIVE;
          w_tx_shft_nxt    = r_tx_buf;
          w_bitcnt_nxt     = '0;
          w_first_fall_nxt = 1'b1;
          w_rdy_clr        = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          if (r_bitcnt == SPI_CNT_FULL) begin
            w_rx_data_nxt = r_rx_shft;
            w_rdy_set     = 1'b1;
          end else begin
            w_frm_err_nxt = 1'b1;
          end
        end else begin
          if (w_sclk_rise) begin
            w_rx_shft_nxt = {r_rx_shft[W-2:0], r_mosi_ff2};
            if (r_bitcnt != SPI_CNT_SAT) w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
          // The first fall only opens the frame; bit 15 is already on MISO.
          if (w_sclk_fall) begin
            if (r_first_fall) w_first_fall_nxt = 1'b0;
            else              w_tx_shft_nxt    = {r_tx_shft[W-2:0], 1'b0};
          end
        end
      end
    endcase

    if (bus.clr_rx_rdy || w_rdy_clr) w_rx_rdy_nxt = 1'b0;
    if (w_rdy_set)                   w_rx_rdy_nxt = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tx_buf     <= '0;
      r_tx_shft    <= '0;
      r_rx_shft    <= '0;
      r_rx_data    <= '0;
      r_bitcnt     <= '0;
      r_first_fall <= 1'b0;
      r_rx_rdy     <= 1'b0;
      r_frm_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_buf     <= w_tx_buf_nxt;
      r_tx_shft    <= w_tx_shft_nxt;
      r_rx_shft    <= w_rx_shft_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_first_fall <= w_first_fall_nxt;
      r_rx_rdy     <= w_rx_rdy_nxt;
      r_frm_err    <= w_frm_err_nxt;
    end
  end

  assign bus.MISO    = (r_state == ACTIVE) ? r_tx_shft[W-1] : 1'b0;
  assign bus.rx_data = r_rx_data;
  assign bus.rx_rdy  = r_rx_rdy;
  assign bus.frm_err = r_frm_err;

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: bit-banged mode-3 master with a scoreboard of per-frame expectations.
module tb_spi_slv16;

  logic clk;
  logic rst_n;

  spi_slv16_if intf ();

  spi_slv16 u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] miso;
    logic [15:0] rx;
    logic        rdy;
    int          nerr;
    bit          good;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_err;
  logic [15:0] m_tx_buf;
  logic [15:0] m_rx_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input logic [15:0] val);
    @(negedge clk);
    intf.tx_data = val;
    intf.tx_ld   = 1'b1;
    @(negedge clk);
    intf.tx_ld   = 1'b0;
    m_tx_buf     = val;
  endtask

  // One frame of nbits SCLK cycles; optional same-cycle clear and mid-frame tx_ld.
  task automatic run_frame(input logic [15:0] cmd, input int nbits, input bit clr_same,
                           input bit do_ld, input logic [15:0] ld_val);
    exp_t        e;
    exp_t        p;
    logic [15:0] miso_w;
    int          nerr;
    e.miso = m_tx_buf;
    e.good = (nbits == 16);
    e.rx   = e.good ? cmd : m_rx_data;
    e.rdy  = e.good;
    e.nerr = e.good ? 0 : 1;
    sb_q.push_back(e);
    if (e.good) m_rx_data = cmd;
    miso_w = '0;

    @(negedge clk);
    intf.SS_n = 1'b0;
    wait_clk(8);
    chk("rdy_cleared_at_start", 32'(intf.rx_rdy), 32'(1'b0));
    for (int i = 0; i < nbits; i++) begin
      intf.SCLK = 1'b0;
      intf.MOSI = (i < 16) ? cmd[15-i] : 1'b1;
      wait_clk(8);
      if (i < 16) miso_w = {miso_w[14:0], intf.MISO};
      intf.SCLK = 1'b1;
      if (do_ld && i == 7) begin
        intf.tx_data = ld_val;
        intf.tx_ld   = 1'b1;
        wait_clk(1);
        intf.tx_ld   = 1'b0;
        m_tx_buf     = ld_val;
        wait_clk(7);
      end else begin
        wait_clk(8);
      end
    end

    intf.SS_n = 1'b1;
    nerr = 0;
    p = e;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (intf.frm_err) nerr++;
      if (i == 2 && clr_same) intf.clr_rx_rdy = 1'b1;
      if (i == 3) begin
        intf.clr_rx_rdy = 1'b0;
        p = sb_q.pop_front();
        chk("rx_rdy_at_end", 32'(intf.rx_rdy), 32'(p.rdy));
        chk("rx_data", 32'(intf.rx_data), 32'(p.rx));
        if (p.good) chk("miso_word", 32'(miso_w), 32'(p.miso));
      end
    end
    chk("frm_err_pulses", 32'(nerr), 32'(p.nerr));
    chk("miso_idle", 32'(intf.MISO), 32'(1'b0));
    if (clr_same) begin
      intf.clr_rx_rdy = 1'b1;
      @(negedge clk);
      intf.clr_rx_rdy = 1'b0;
      @(negedge clk);
      chk("rx_rdy_after_clr", 32'(intf.rx_rdy), 32'(1'b0));
    end
    wait_clk(4);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_tx_buf  = '0;
    m_rx_data = '0;
    intf.SS_n       = 1'b1;
    intf.SCLK       = 1'b1;
    intf.MOSI       = 1'b0;
    intf.tx_data    = '0;
    intf.tx_ld      = 1'b0;
    intf.clr_rx_rdy = 1'b0;
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);

    chk("reset_miso", 32'(intf.MISO), 32'(1'b0));
    chk("reset_rx_data", 32'(intf.rx_data), 32'(16'h0000));
    chk("reset_rx_rdy", 32'(intf.rx_rdy), 32'(1'b0));
    chk("reset_frm_err", 32'(intf.frm_err), 32'(1'b0));

    // Back-to-back frames.
    tx_load(16'hA5C3);
    run_frame(16'h1234, 16, 1'b0, 1'b0, 16'h0);
    tx_load(16'hFFFF);
    run_frame(16'h0001, 16, 1'b0, 1'b0, 16'h0);

    // Short and long frames leave rx_data alone.
    run_frame(16'hDEAD, 10, 1'b0, 1'b0, 16'h0);
    run_frame(16'hCAFE, 17, 1'b0, 1'b0, 16'h0);

    // Same-cycle clear loses to set, then a later clear wins.
    tx_load(16'h3C3C);
    run_frame(16'h5A5A, 16, 1'b1, 1'b0, 16'h0);

    // tx_ld mid-frame only affects the next frame.
    tx_load(16'h8001);
    run_frame(16'h7E81, 16, 1'b0, 1'b1, 16'h0F0F);
    run_frame(16'h0420, 16, 1'b0, 1'b0, 16'h0);

    // Reset mid-frame after 8 bits.
    tx_load(16'h1357);
    @(negedge clk);
    intf.SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 8; i++) begin
      intf.SCLK = 1'b0;
      intf.MOSI = i[0];
      wait_clk(8);
      intf.SCLK = 1'b1;
      wait_clk(8);
    end
    rst_n = 1'b0;
    wait_clk(1);
    chk("rst_mid_miso", 32'(intf.MISO), 32'(1'b0));
    chk("rst_mid_rx_rdy", 32'(intf.rx_rdy), 32'(1'b0));
    chk("rst_mid_frm_err", 32'(intf.frm_err), 32'(1'b0));
    chk("rst_mid_rx_data", 32'(intf.rx_data), 32'(16'h0000));
    intf.SS_n = 1'b1;
    intf.SCLK = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    m_tx_buf  = '0;
    m_rx_data = '0;
    begin
      int nerr_rst;
      nerr_rst = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (intf.frm_err) nerr_rst++;
      end
      chk("rst_no_frm_err", 32'(nerr_rst), 32'(0));
    end
    run_frame(16'hBEEF, 16, 1'b0, 1'b0, 16'h0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
